// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed 8-digit 7-segment scan and emits whole frames over valid/ready.
// Define SEG_SCAN_DECODER_ERRCNT_EN to build the saturating illegal-anode event counter.
module seg_scan_decoder #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  input  logic        out_ready,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic        out_valid,
  output logic        overflow,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [7:0]  an_q;
  logic [6:0]  seg_q;
  logic [7:0]  seen, seen_cap;
  logic [31:0] shadow, shadow_nxt;
  logic [7:0]  shadow_blank, shblank_nxt;
  logic        an_legal, an_illegal, same, an_moved, cnt_reached;
  logic        capture, frame_done;
  logic [3:0]  glyph_val;
  logic        glyph_blank;

  assign an_legal    = ($countones(~an) == 1);
  assign an_illegal  = ($countones(~an) > 1);
  assign same        = (an == an_q) && (seg == seg_q);
  assign an_moved    = (an != an_q);
  assign cnt_reached = ({1'b0, cnt} + 9'd1) >= 9'(SETTLE);

  always_comb begin
    {glyph_blank, glyph_val} = 5'h10;
    case (seg)
      7'h40: {glyph_blank, glyph_val} = 5'h00;
      7'h79: {glyph_blank, glyph_val} = 5'h01;
      7'h24: {glyph_blank, glyph_val} = 5'h02;
      7'h30: {glyph_blank, glyph_val} = 5'h03;
      7'h19: {glyph_blank, glyph_val} = 5'h04;
      7'h12: {glyph_blank, glyph_val} = 5'h05;
      7'h02: {glyph_blank, glyph_val} = 5'h06;
      7'h78: {glyph_blank, glyph_val} = 5'h07;
      7'h00: {glyph_blank, glyph_val} = 5'h08;
      7'h10: {glyph_blank, glyph_val} = 5'h09;
      7'h08: {glyph_blank, glyph_val} = 5'h0A;
      7'h03: {glyph_blank, glyph_val} = 5'h0B;
      7'h46: {glyph_blank, glyph_val} = 5'h0C;
      7'h21: {glyph_blank, glyph_val} = 5'h0D;
      7'h06: {glyph_blank, glyph_val} = 5'h0E;
      7'h0E: {glyph_blank, glyph_val} = 5'h0F;
      default: {glyph_blank, glyph_val} = 5'h10;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      an_q  <= 8'hFF;
      seg_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      an_q  <= an;
      seg_q <= seg;
    end
  end

  // The first cycle a legal anode is seen counts as one settled cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (an_illegal) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: if (an_legal) begin
          state_n = S_SETTLE;
          cnt_n   = 8'd1;
        end
        S_SETTLE: begin
          if (!an_legal) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else if (!same) begin
            cnt_n = 8'd1;
          end else if (cnt_reached) begin
            state_n = S_HOLD;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        S_HOLD: if (an_moved) begin
          state_n = an_legal ? S_SETTLE : S_IDLE;
          cnt_n   = an_legal ? 8'd1 : 8'd0;
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    capture = (state == S_SETTLE) && an_legal && same && cnt_reached;
  end

  always_comb begin
    shadow_nxt  = shadow;
    shblank_nxt = shadow_blank;
    for (int i = 0; i < 8; i++) begin
      if (capture && !an[i]) begin
        shadow_nxt[4*i +: 4] = glyph_val;
        shblank_nxt[i]       = glyph_blank;
      end
    end
  end

  assign seen_cap   = capture ? (seen | ~an) : seen;
  assign frame_done = capture && (&seen_cap);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen         <= '0;
      shadow       <= '0;
      shadow_blank <= '0;
      digits       <= '0;
      blank        <= 8'hFF;
      out_valid    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      shadow       <= shadow_nxt;
      shadow_blank <= shblank_nxt;
      seen         <= frame_done ? 8'h00 : seen_cap;
      if (frame_done) begin
        digits    <= shadow_nxt;
        blank     <= shblank_nxt;
        out_valid <= 1'b1;
        // An unaccepted frame being replaced is lost; remember it until reset.
        if (out_valid && !out_ready) overflow <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SEG_SCAN_DECODER_ERRCNT_EN
  logic prev_illegal;
  assign prev_illegal = ($countones(~an_q) > 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (an_illegal && !prev_illegal && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboarded bench for seg_scan_decoder: run-length reference model feeds a frame queue, a monitor checks handshakes.
module tb_seg_scan_decoder;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  an = 8'hFF;
  logic [6:0]  seg = 7'h7F;
  logic        out_ready = 1'b0;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic        out_valid, overflow;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg), .out_ready(out_ready),
    .digits(digits), .blank(blank), .out_valid(out_valid),
    .overflow(overflow), .err_cnt(err_cnt)
  );

  localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  b;
  } frame_t;

  int checks = 0;
  int errors = 0;

  frame_t exp_q[$];
  logic [3:0] m_val [8];
  logic [7:0] m_blank, m_seen;
  int   run, m_err;
  bit   held, m_valid, m_ovf, p_ill;
  logic [7:0] p_an;
  logic [6:0] p_seg;

  frame_t last_frame, mon_f;
  int n_frames = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 16; k++)
      if (GLY[k] == s) return {1'b0, k[3:0]};
    return 5'h10;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) m_val[i] = '0;
    m_blank = '0; m_seen = '0;
    run = 0; held = 0; m_valid = 0; m_ovf = 0; m_err = 0;
    p_an = 8'hFF; p_seg = '0; p_ill = 0;
  endtask

  // A digit is taken once its anode/segment pair has been stable for SETTLE cycles,
  // and not again until the anode moves.
  task automatic model(input logic [7:0] a, input logic [6:0] s, input bit r);
    int nz;
    bit ill, leg, done;
    logic [4:0] g;
    frame_t f;
    nz = $countones(~a);
    ill = (nz >= 2);
    leg = (nz == 1);
    done = 0;
    if (ill) begin
      if (!p_ill && m_err < 255) m_err++;
      run = 0; held = 0;
    end else if (!leg) begin
      run = 0; held = 0;
    end else begin
      if (held) begin
        if (a != p_an) begin held = 0; run = 1; end
      end else if (run > 0 && a == p_an && s == p_seg) begin
        run++;
      end else begin
        run = 1;
      end
      if (!held && run >= SETTLE) begin
        g = ref_decode(s);
        for (int i = 0; i < 8; i++)
          if (!a[i]) begin
            m_val[i] = g[3:0]; m_blank[i] = g[4]; m_seen[i] = 1'b1;
          end
        held = 1;
        if (&m_seen) begin
          done = 1;
          m_seen = '0;
        end
      end
    end
    if (done) begin
      for (int i = 0; i < 8; i++) f.d[4*i +: 4] = m_val[i];
      f.b = m_blank;
      if (m_valid && !r) begin
        void'(exp_q.pop_back());
        m_ovf = 1;
      end
      exp_q.push_back(f);
      m_valid = 1;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    p_an = a; p_seg = s; p_ill = ill;
  endtask

  task automatic cyc(input logic [7:0] a, input logic [6:0] s, input bit r);
    @(posedge clk); #1;
    an = a; seg = s; out_ready = r;
    model(a, s, r);
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) cyc(8'hFF, 7'h7F, r);
  endtask

  function automatic logic [7:0][6:0] mk(input int base);
    logic [7:0][6:0] g;
    for (int i = 0; i < 8; i++) g[i] = GLY[base + i];
    return g;
  endfunction

  task automatic scan(input logic [7:0][6:0] g, input int hold, input bit r,
                      input int short_dig, input int ndig);
    for (int i = 0; i < ndig; i++)
      for (int c = 0; c < ((i == short_dig) ? 3 : hold); c++)
        cyc(~(8'h01 << i), g[i], r);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    an = 8'hFF; seg = 7'h7F; out_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_digits", {8'h0, digits}, 40'h0);
    chk("rst_blank", {32'h0, blank}, {32'h0, 8'hFF});
    chk("rst_valid", {39'h0, out_valid}, 40'h0);
    chk("rst_overflow", {39'h0, overflow}, 40'h0);
    chk("rst_err_cnt", {32'h0, err_cnt}, 40'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_unexpected: got %h %h expected no frame", digits, blank);
      end else begin
        mon_f = exp_q.pop_front();
        chk("frame", {digits, blank}, mon_f);
      end
      last_frame = {digits, blank};
      n_frames++;
    end
  end

  initial begin
    logic [7:0][6:0] g;
    logic [7:0] a;
    logic [6:0] s;
    int nf, p, i, j, h, gl;
    model_reset();
    do_reset();

    // Clean scan of 0..7
    nf = n_frames;
    scan(mk(0), 6, 1, -1, 8);
    idle(4, 1);
    chk("scan_frames", 40'(n_frames - nf), 40'd1);
    chk("scan_frame", last_frame, {32'h76543210, 8'h00});

    // Illegal glyph on digit 3
    g = mk(0); g[3] = 7'h7F;
    nf = n_frames;
    scan(g, 6, 1, -1, 8);
    idle(4, 1);
    chk("blank_frames", 40'(n_frames - nf), 40'd1);
    chk("blank_frame", last_frame, {32'h76540210, 8'h08});

    // Digit 5 held only 3 cycles: no frame
    do_reset();
    nf = n_frames;
    scan(mk(0), 6, 1, 5, 8);
    idle(4, 1);
    chk("short_valid", {39'h0, out_valid}, 40'h0);
    chk("short_frames", 40'(n_frames - nf), 40'd0);

    // Two frames, consumer stalled
    do_reset();
    nf = n_frames;
    scan(mk(0), 6, 0, -1, 8);
    scan(mk(8), 6, 0, -1, 8);
    idle(3, 0);
    chk("ovf_valid", {39'h0, out_valid}, 40'h1);
    chk("ovf_frame_held", {digits, blank}, {32'hFEDCBA98, 8'h00});
    chk("ovf_flag", {39'h0, overflow}, 40'h1);
    idle(3, 1);
    chk("ovf_frames", 40'(n_frames - nf), 40'd1);
    chk("ovf_last", last_frame, {32'hFEDCBA98, 8'h00});
    chk("ovf_sticky", {39'h0, overflow}, 40'h1);

    // Two illegal-anode episodes of 5 cycles each
    do_reset();
    repeat (2) begin
      repeat (5) cyc(8'hFC, 7'h40, 1);
      idle(2, 1);
    end
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
    chk("err_cnt", {32'h0, err_cnt}, 40'd2);
`else
    chk("err_cnt", {32'h0, err_cnt}, 40'd0);
`endif

    // Reset after 5 captured digits, then full scan
    do_reset();
    scan(mk(8), 6, 1, -1, 5);
    do_reset();
    nf = n_frames;
    scan(mk(0), 6, 1, -1, 8);
    idle(4, 1);
    chk("rst_mid_frames", 40'(n_frames - nf), 40'd1);
    chk("rst_mid_frame", last_frame, {32'h76543210, 8'h00});

    // Randomized scanning with glitches, idle and illegal anodes, random back-pressure
    do_reset();
    for (int n = 0; n < 600; n++) begin
      p = $urandom_range(0, 99);
      i = $urandom_range(0, 7);
      if (p < 88) a = ~(8'h01 << i);
      else if (p < 94) a = 8'hFF;
      else begin
        j = (i + 1 + $urandom_range(0, 6)) % 8;
        a = ~((8'h01 << i) | (8'h01 << j));
      end
      s = ($urandom_range(0, 9) < 9) ? GLY[$urandom_range(0, 15)] : 7'($urandom);
      h = $urandom_range(1, 8);
      gl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, h - 1) : -1;
      for (int c = 0; c < h; c++)
        cyc(a, (c == gl) ? (s ^ 7'h01) : s, $urandom_range(0, 9) < 7);
    end
    idle(10, 1);
    chk("rand_drained", 40'(exp_q.size()), 40'd0);
    chk("rand_valid", {39'h0, out_valid}, 40'h0);
    chk("rand_overflow", {39'h0, overflow}, {39'h0, m_ovf});
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
    chk("rand_err_cnt", {32'h0, err_cnt}, 40'(m_err));
`else
    chk("rand_err_cnt", {32'h0, err_cnt}, 40'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4: consecutive cycles an/seg must hold unchanged before a digit is captured; legal range 1..255.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 an  input  8  multiplexed display anode enables, active-low; an[i]=0 selects digit i.
REQ-005 seg  input  7  segment lines, active-low; seg[0]=a ... seg[6]=g.
REQ-006 digits  output  32  decoded frame; digits[4i+3:4i] = hex value of digit i.
REQ-007 blank  output  8  blank[i]=1 when digit i's pattern was not a legal hex glyph.
REQ-008 out_valid  output  1  a complete frame is held on digits/blank.
REQ-009 out_ready  input  1  consumer accepts the frame.
REQ-010 overflow  output  1  sticky; a frame completed while the previous one was unaccepted.
REQ-011 err_cnt  output  8  count of illegal anode events, saturating at 8'hFF.

Function
REQ-012 Glyph table (seg[6:0] hex -> value): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F; any other pattern -> value 0, blank bit 1.
REQ-013 Anode classes: exactly one bit low = legal; all high = idle; two or more low = illegal.
REQ-014 FSM states: IDLE, SETTLE, HOLD.
REQ-015 IDLE -> SETTLE when an is legal; settle counter loaded to 1.
REQ-016 SETTLE: counter increments each cycle an and seg equal the previous cycle's values; any change restarts SETTLE with counter 1 (or IDLE if an no longer legal).
REQ-017 SETTLE -> HOLD when counter reaches SETTLE; on that cycle the glyph is decoded into a shadow slot for the selected digit and its seen bit is set.
REQ-018 HOLD: no further capture until an changes; then IDLE/SETTLE per REQ-015; seg changes in HOLD are ignored.
REQ-019 Illegal anode in any state: FSM -> IDLE, err_cnt increments once per entry into illegal (not per cycle).
REQ-020 Re-capture of an already-seen digit overwrites its shadow slot.
REQ-021 When all 8 seen bits are set: shadow copied to digits/blank, out_valid set the next cycle, seen bits cleared the same cycle.
REQ-022 Handshake: transfer occurs on a cycle with out_valid=1 and out_ready=1; out_valid drops the next cycle unless a new frame completes that same cycle, in which case out_valid stays 1 and the new frame loads.
REQ-023 digits/blank stable while out_valid=1 and out_ready=0.
REQ-024 Frame completes while out_valid=1 and out_ready=0: new frame overwrites digits/blank, out_valid stays 1, overflow set; cleared only by reset.
REQ-025 Capture-to-out_valid latency: 1 cycle after the capture cycle completing the eighth digit.

Reset
REQ-026 reset low asynchronously forces: FSM IDLE, settle counter 0, seen 0, shadow 0, digits 0, blank 8'hFF, out_valid 0, overflow 0, err_cnt 0.
REQ-027 Reset mid-frame discards all partially captured digits; capture resumes on the first legal anode after release.

Configuration
REQ-028 Macro SEG_SCAN_DECODER_ERRCNT_EN defined: err_cnt implemented per REQ-019.
REQ-029 Macro undefined: no counter logic; err_cnt tied to 8'h00; illegal anodes still force IDLE.

Verification
REQ-030 Scan an=FE..7F with glyphs 0..7, 6 cycles each, SETTLE=4, out_ready=1 -> digits=32'h76543210, blank=0, out_valid one cycle.
REQ-031 Digit 3 driven seg=7F, others legal -> blank=8'h08, digits[15:12]=0.
REQ-032 Digit held 3 cycles (SETTLE=4) then anode moves -> digit not captured; no frame after 8 positions.
REQ-033 Two frames, out_ready=0 throughout -> out_valid=1, digits = second frame, overflow=1.
REQ-034 an=8'hFC for 5 cycles, twice, macro defined -> err_cnt=2; macro undefined -> err_cnt=0.
REQ-035 reset low after 5 digits captured, then full scan -> frame equals post-reset scan only, reset outputs per REQ-026 observed.
